// File: rtl/robot_step_executor.sv
// Robot motion stage: paces steps with a timer, requests one controller command
// per step and applies it to the row/column/orientation pose, refusing illegal moves.
module robot_step_executor #(
  parameter int         STEP_CYCLES = 200000000,
  parameter int         CMD_TIMEOUT = 1024,
  parameter int         ROWS        = 10,
  parameter int         COLS        = 20,
  parameter int         INIT_ROW    = 1,
  parameter int         INIT_COL    = 1,
  parameter logic [1:0] INIT_ORIENT = 2'b00
) (
  input  logic       clock_50,
  input  logic       reset_key,
  output logic       cmd_req,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic       blocked_ahead,
  output logic [5:0] robot_row,
  output logic [5:0] robot_column,
  output logic [1:0] robot_orientation,
  output logic       step_done,
  output logic       clean_pulse,
  output logic       bump,
  output logic       timeout_flag
);

  localparam int TW = $clog2(STEP_CYCLES + 1);
  localparam int CW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_TIMEOUT - 1);
  localparam logic [5:0]    ROW_MAX   = 6'(ROWS);
  localparam logic [5:0]    COL_MAX   = 6'(COLS);

  localparam logic [1:0] OR_N = 2'b00;
  localparam logic [1:0] OR_S = 2'b01;
  localparam logic [1:0] OR_E = 2'b10;
  localparam logic [1:0] OR_W = 2'b11;

  localparam logic [2:0] CMD_HOLD  = 3'b000;
  localparam logic [2:0] CMD_FWD   = 3'b001;
  localparam logic [2:0] CMD_LEFT  = 3'b010;
  localparam logic [2:0] CMD_RIGHT = 3'b011;
  localparam logic [2:0] CMD_CLEAN = 3'b100;

  typedef enum logic [1:0] {S_WAIT, S_REQUEST, S_EXECUTE, S_DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [CW-1:0] to_cnt;
  logic          to_mark;
  logic [2:0]    cmd_cap;
  logic          blk_cap;
  logic          fwd_ok;

  function automatic logic [1:0] turn_left(input logic [1:0] o);
    case (o)
      OR_N:    turn_left = OR_W;
      OR_W:    turn_left = OR_S;
      OR_S:    turn_left = OR_E;
      default: turn_left = OR_N;
    endcase
  endfunction

  function automatic logic [1:0] turn_right(input logic [1:0] o);
    case (o)
      OR_N:    turn_right = OR_E;
      OR_E:    turn_right = OR_S;
      OR_S:    turn_right = OR_W;
      default: turn_right = OR_N;
    endcase
  endfunction

  // A step ahead is legal only if the target cell stays inside 1..ROWS x 1..COLS.
  function automatic logic in_bounds(input logic [1:0] o, input logic [5:0] r,
                                     input logic [5:0] c);
    case (o)
      OR_N:    in_bounds = (r > 6'd1);
      OR_S:    in_bounds = (r < ROW_MAX);
      OR_E:    in_bounds = (c < COL_MAX);
      default: in_bounds = (c > 6'd1);
    endcase
  endfunction

  always_comb begin
    fwd_ok = in_bounds(robot_orientation, robot_row, robot_column) && !blk_cap;
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state             <= S_WAIT;
      timer             <= '0;
      to_cnt            <= '0;
      to_mark           <= 1'b0;
      cmd_cap           <= CMD_HOLD;
      blk_cap           <= 1'b0;
      robot_row         <= 6'(INIT_ROW);
      robot_column      <= 6'(INIT_COL);
      robot_orientation <= INIT_ORIENT;
      cmd_req           <= 1'b0;
      step_done         <= 1'b0;
      clean_pulse       <= 1'b0;
      bump              <= 1'b0;
      timeout_flag      <= 1'b0;
    end else begin
      step_done    <= 1'b0;
      clean_pulse  <= 1'b0;
      bump         <= 1'b0;
      timeout_flag <= 1'b0;
      case (state)
        S_WAIT: begin
          if (timer == STEP_LAST) begin
            timer   <= '0;
            cmd_req <= 1'b1;
            state   <= S_REQUEST;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_REQUEST: begin
          to_cnt <= to_cnt + 1'b1;
          // A command arriving in the expiring cycle takes priority over the timeout.
          if (cmd_valid) begin
            cmd_cap <= cmd;
            blk_cap <= blocked_ahead;
            to_mark <= 1'b0;
            cmd_req <= 1'b0;
            state   <= S_EXECUTE;
          end else if (to_cnt == CMD_LAST) begin
            cmd_cap <= CMD_HOLD;
            blk_cap <= 1'b0;
            to_mark <= 1'b1;
            cmd_req <= 1'b0;
            state   <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (cmd_cap)
            CMD_FWD: begin
              if (fwd_ok) begin
                case (robot_orientation)
                  OR_N:    robot_row    <= robot_row - 6'd1;
                  OR_S:    robot_row    <= robot_row + 6'd1;
                  OR_E:    robot_column <= robot_column + 6'd1;
                  default: robot_column <= robot_column - 6'd1;
                endcase
              end else begin
                bump <= 1'b1;
              end
            end
            CMD_LEFT:  robot_orientation <= turn_left(robot_orientation);
            CMD_RIGHT: robot_orientation <= turn_right(robot_orientation);
            CMD_CLEAN: clean_pulse <= 1'b1;
            default:   ;
          endcase
          step_done    <= 1'b1;
          timeout_flag <= to_mark;
          state        <= S_DONE;
        end
        S_DONE: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_robot_step_executor.sv
// Directed bench for robot_step_executor with a short step period and command timeout.
module tb_robot_step_executor;

  localparam logic [2:0] HOLD = 3'b000, FWD = 3'b001, TL = 3'b010, TR = 3'b011, CLN = 3'b100;
  localparam logic [1:0] N = 2'b00, S = 2'b01, E = 2'b10, W = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'b000;
  logic       blocked = 1'b0;
  logic       cmd_req, step_done, clean_pulse, bump, timeout_flag;
  logic [5:0] robot_row, robot_column;
  logic [1:0] robot_orientation;

  int total = 0;
  int bad = 0;

  robot_step_executor #(
    .STEP_CYCLES(8),
    .CMD_TIMEOUT(16)
  ) dut (
    .clock_50         (clk),
    .reset_key        (rst_n),
    .cmd_req          (cmd_req),
    .cmd_valid        (cmd_valid),
    .cmd              (cmd),
    .blocked_ahead    (blocked),
    .robot_row        (robot_row),
    .robot_column     (robot_column),
    .robot_orientation(robot_orientation),
    .step_done        (step_done),
    .clean_pulse      (clean_pulse),
    .bump             (bump),
    .timeout_flag     (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pose(input string tag, input logic [5:0] er, input logic [5:0] ec,
                          input logic [1:0] eo);
    chk({tag, "_row"}, 32'(robot_row), 32'(er));
    chk({tag, "_col"}, 32'(robot_column), 32'(ec));
    chk({tag, "_ori"}, 32'(robot_orientation), 32'(eo));
  endtask

  // Counts falling edges until cmd_req is seen, bounded so a dead DUT cannot hang the run.
  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_req && n < 40);
  endtask

  task automatic step(input string tag, input logic [2:0] c, input logic blk, input int exp_wait,
                      input logic [5:0] er, input logic [5:0] ec, input logic [1:0] eo,
                      input logic eb, input logic ecl);
    int n;
    wait_req(n);
    chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
    cmd_valid = 1'b1;
    cmd       = c;
    blocked   = blk;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = HOLD;
    blocked   = 1'b0;
    chk({tag, "_exec_req"}, 32'(cmd_req), 32'd0);
    chk({tag, "_exec_done"}, 32'(step_done), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(step_done), 32'd1);
    chk({tag, "_bump"}, 32'(bump), 32'(eb));
    chk({tag, "_clean"}, 32'(clean_pulse), 32'(ecl));
    chk({tag, "_tmo"}, 32'(timeout_flag), 32'd0);
    chk_pose(tag, er, ec, eo);
  endtask

  initial begin
    int n;
    int hi;

    repeat (3) @(negedge clk);
    chk_pose("reset", 6'd1, 6'd1, N);
    chk("reset_req", 32'(cmd_req), 32'd0);
    chk("reset_done", 32'(step_done), 32'd0);
    chk("reset_bump", 32'(bump), 32'd0);
    rst_n = 1'b1;

    step("fwd_north_edge", FWD, 1'b0, 8, 6'd1, 6'd1, N, 1'b1, 1'b0);
    step("turn_right_e", TR, 1'b0, 9, 6'd1, 6'd1, E, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("fwd_east", FWD, 1'b0, 9, 6'd1, 6'(2 + i), E, 1'b0, 1'b0);

    // cmd_valid outside REQUEST must be ignored.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = FWD;
    @(negedge clk);
    chk("ignore_done", 32'(step_done), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = HOLD;
    chk_pose("ignore", 6'd1, 6'd4, E);
    step("hold_after_ignore", HOLD, 1'b0, 6, 6'd1, 6'd4, E, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++)
      step("fwd_east_run", FWD, 1'b0, 9, 6'd1, 6'(5 + i), E, 1'b0, 1'b0);
    step("fwd_east_edge", FWD, 1'b0, 9, 6'd1, 6'd20, E, 1'b1, 1'b0);
    step("turn_right_s", TR, 1'b0, 9, 6'd1, 6'd20, S, 1'b0, 1'b0);
    step("fwd_blocked", FWD, 1'b1, 9, 6'd1, 6'd20, S, 1'b1, 1'b0);

    // No controller answer: cmd_req stays up for exactly 16 cycles.
    wait_req(n);
    chk("tmo_wait", 32'(n), 32'd9);
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!cmd_req) break;
      hi++;
    end
    chk("tmo_req_cycles", 32'(hi), 32'd16);
    chk("tmo_exec_done", 32'(step_done), 32'd0);
    @(negedge clk);
    chk("tmo_done", 32'(step_done), 32'd1);
    chk("tmo_flag", 32'(timeout_flag), 32'd1);
    chk("tmo_bump", 32'(bump), 32'd0);
    chk("tmo_clean", 32'(clean_pulse), 32'd0);
    chk_pose("tmo", 6'd1, 6'd20, S);
    @(negedge clk);
    chk("tmo_flag_clear", 32'(timeout_flag), 32'd0);
    chk("tmo_done_clear", 32'(step_done), 32'd0);

    step("fwd_south_0", FWD, 1'b0, 8, 6'd2, 6'd20, S, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++)
      step("fwd_south", FWD, 1'b0, 9, 6'(2 + i), 6'd20, S, 1'b0, 1'b0);
    step("turn_right_w", TR, 1'b0, 9, 6'd5, 6'd20, W, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++)
      step("fwd_west", FWD, 1'b0, 9, 6'd5, 6'(19 - i), W, 1'b0, 1'b0);

    step("clean", CLN, 1'b0, 9, 6'd5, 6'd7, W, 1'b0, 1'b1);
    step("left_1", TL, 1'b0, 9, 6'd5, 6'd7, S, 1'b0, 1'b0);
    step("left_2", TL, 1'b0, 9, 6'd5, 6'd7, E, 1'b0, 1'b0);
    step("left_3", TL, 1'b0, 9, 6'd5, 6'd7, N, 1'b0, 1'b0);
    step("left_4", TL, 1'b0, 9, 6'd5, 6'd7, W, 1'b0, 1'b0);
    step("undef_cmd", 3'b111, 1'b0, 9, 6'd5, 6'd7, W, 1'b0, 1'b0);

    step("move_a", FWD, 1'b0, 9, 6'd5, 6'd6, W, 1'b0, 1'b0);
    step("move_b", FWD, 1'b0, 9, 6'd5, 6'd5, W, 1'b0, 1'b0);

    // Asynchronous reset while a request is pending.
    wait_req(n);
    chk("mid_wait", 32'(n), 32'd9);
    rst_n = 1'b0;
    #1;
    chk_pose("mid_reset", 6'd1, 6'd1, N);
    chk("mid_reset_req", 32'(cmd_req), 32'd0);
    chk("mid_reset_done", 32'(step_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_reset_hold_done", 32'(step_done), 32'd0);
    chk("mid_reset_hold_req", 32'(cmd_req), 32'd0);
    rst_n = 1'b1;
    step("after_reset", HOLD, 1'b0, 8, 6'd1, 6'd1, N, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/robot_step_executor.md
Name: robot_step_executor

Overview:
- Motion stage feeding the robot position state consumed by the world top level.
- Paces robot steps with a step timer, requests one command per step from the robot controller, and applies it to row/column/orientation.
- Refuses illegal moves: map boundary or wall reported by the map.
- Runs on the 50 MHz board clock; one step every STEP_CYCLES cycles (4 s at default).

Parameters:
- STEP_CYCLES, 200000000, clock cycles between step requests (4 s at 50 MHz).
- CMD_TIMEOUT, 1024, cycles to wait for cmd_valid before treating the step as HOLD.
- ROWS, 10, map rows; legal row range 1..ROWS.
- COLS, 20, map columns; legal column range 1..COLS.
- INIT_ROW, 1, row after reset.
- INIT_COL, 1, column after reset.
- INIT_ORIENT, 2'b00, orientation after reset (north).

Ports:
- clock_50  in  1  board clock, 50 MHz.
- reset_key  in  1  asynchronous, active-low reset.
- cmd_req  out  1  high while waiting for a controller command.
- cmd_valid  in  1  controller command present.
- cmd  in  3  000 HOLD, 001 FORWARD, 010 TURN_LEFT, 011 TURN_RIGHT, 100 CLEAN; others = HOLD.
- blocked_ahead  in  1  map reports a wall in the cell ahead of the current pose.
- robot_row  out  6  current row, 1..ROWS.
- robot_column  out  6  current column, 1..COLS.
- robot_orientation  out  2  00 north, 01 south, 10 east, 11 west.
- step_done  out  1  one-cycle pulse after each step is applied.
- clean_pulse  out  1  one-cycle pulse, concurrent with step_done, on a CLEAN step.
- bump  out  1  one-cycle pulse, concurrent with step_done, on a refused FORWARD.
- timeout_flag  out  1  one-cycle pulse, concurrent with step_done, when CMD_TIMEOUT expires.

Behaviour:
- Reset (reset_key low, asynchronous):
  - state WAIT; timer and timeout counters 0.
  - robot_row = INIT_ROW, robot_column = INIT_COL, robot_orientation = INIT_ORIENT.
  - cmd_req and all pulse outputs 0.
- WAIT:
  - The timer counts up each cycle.
  - At count STEP_CYCLES-1: clear the timer, go to REQUEST.
  - The first request therefore raises cmd_req exactly STEP_CYCLES cycles after reset release.
- REQUEST:
  - cmd_req = 1; the timeout counter increments each cycle.
  - cmd_valid high in a cycle where cmd_req = 1: capture cmd and blocked_ahead in that cycle, go to EXECUTE.
  - If cmd_valid is also high in the expiring cycle, cmd_valid wins.
  - After CMD_TIMEOUT cycles with no cmd_valid: latch HOLD, set an internal timeout marker, go to EXECUTE.
  - cmd_valid outside REQUEST is ignored.
- EXECUTE (one cycle; cmd_req = 0): pose registers update at the end of this cycle.
  - FORWARD, north: row-1. South: row+1. East: column+1. West: column-1.
  - FORWARD is refused if the target leaves 1..ROWS or 1..COLS, or if the captured blocked_ahead = 1. A refused move leaves the pose unchanged and arms bump.
  - TURN_LEFT: N->W, W->S, S->E, E->N. TURN_RIGHT: N->E, E->S, S->W, W->N. The position does not change.
  - CLEAN: the pose does not change; arms clean_pulse.
  - HOLD or an undefined code: no change.
- DONE (one cycle):
  - step_done = 1, plus whichever of clean_pulse, bump, timeout_flag are armed.
  - Clear the timeout counter, return to WAIT; the timer has already restarted at 0.
  - Step period is STEP_CYCLES + request wait + 2 cycles.
- Arithmetic and outputs:
  - Boundary comparisons use unsigned 6-bit values.
  - Row and column never take the value 0 or exceed ROWS/COLS.
  - Outputs are registered; the pose is stable for the whole step interval.
- Reset mid-operation: an immediate return to the reset values from any state. No pulse is emitted and no partial pose update occurs.

Test Plan:
- STEP_CYCLES=8, reset release -> cmd_req rises at cycle 8. Give cmd_valid with FORWARD, orientation north, row 1 -> pose stays (1,1,N); bump and step_done pulse together.
- From (1,1,N): TURN_RIGHT then FORWARD ×3, blocked_ahead = 0 -> orientation E, column 4, row 1. Exactly one step_done per step; no bump.
- At (1,20,E): FORWARD -> refused, bump = 1. Then TURN_RIGHT, then FORWARD with blocked_ahead = 1 -> refused, bump = 1, pose (1,20,S).
- No cmd_valid, CMD_TIMEOUT=16 -> cmd_req high for 16 cycles, then timeout_flag and step_done, pose unchanged.
- CLEAN at (5,7,W) -> clean_pulse concurrent with step_done, pose unchanged. Four TURN_LEFTs return to W.
- reset_key low during REQUEST after two moves -> outputs immediately (1,1,N), cmd_req 0, no step_done. After release, the next cmd_req comes 8 cycles later.
